// File: rtl/ulpi_reg_write.sv
// ulpi_reg_write
// Link-side ULPI register write engine. A one-cycle request latches a 6-bit
// register address and an 8-bit value. The engine then waits until the link
// owns the bus, drives the immediate-address register-write TXCMD and then
// the data byte. It finishes the transfer with STP. If the PHY takes the bus
// back mid-transfer, the engine re-issues the write up to MAX_RETRY times and
// then gives up with an error pulse.
//
// Ports
//   clk_ulpi_i   60 MHz ULPI clock from the PHY
//   rst_i        synchronous active-high reset
//   prw_i        write request pulse, sampled only while busy_o=0
//   addr_i       register address, latched on an accepted request
//   reg_val_i    value to write, latched on an accepted request
//   busy_o       high from the cycle after an accepted request through the
//                done/err cycle
//   done_o       one-cycle pulse when the PHY has accepted the write
//   err_o        one-cycle pulse when retries are exhausted
//   dir_i        ULPI DIR (1 = PHY owns the bus)
//   nxt_i        ULPI NXT
//   data_o       link-driven ULPI data; the external tristate is enabled while DIR=0
//   stp_o        ULPI STP
//
// State table
//   IDLE     | no transfer; waiting for a request
//   WAIT_BUS | waiting for DIR low this cycle and the previous one (turnaround)
//   TXCMD    | driving the register-write TXCMD until NXT
//   DATA     | driving the register value until NXT
//   STOP     | one cycle of STP
//   FINISH   | done pulse, last busy cycle
module ulpi_reg_write #(
    parameter int MAX_RETRY = 3
) (
    input  logic       clk_ulpi_i,
    input  logic       rst_i,
    input  logic       prw_i,
    input  logic [5:0] addr_i,
    input  logic [7:0] reg_val_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       dir_i,
    input  logic       nxt_i,
    output logic [7:0] data_o,
    output logic       stp_o
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        TXCMD,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t          state_q;
    logic [5:0]      addr_q;
    logic [7:0]      val_q;
    logic [RW-1:0]   retry_q;
    logic            dir_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            stp_q;
    logic [7:0]      data_q;

    always_ff @(posedge clk_ulpi_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            val_q   <= '0;
            retry_q <= '0;
            // Assume the PHY may own the bus out of reset, so a full
            // turnaround is seen before the first TXCMD.
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stp_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            dir_q  <= dir_i;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            stp_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    data_q <= 8'h00;
                    // busy_q is still high in the err cycle, which is spent in
                    // IDLE, so a request there is ignored.
                    if (prw_i && !busy_q) begin
                        addr_q  <= addr_i;
                        val_q   <= reg_val_i;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_BUS;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                WAIT_BUS: begin
                    if (!dir_i && !dir_q) begin
                        data_q  <= {2'b10, addr_q};
                        state_q <= TXCMD;
                    end else begin
                        data_q <= 8'h00;
                    end
                end

                TXCMD, DATA: begin
                    // A PHY abort takes priority over NXT.
                    if (dir_i) begin
                        data_q <= 8'h00;
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= WAIT_BUS;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (nxt_i) begin
                        if (state_q == TXCMD) begin
                            data_q  <= val_q;
                            state_q <= DATA;
                        end else begin
                            data_q  <= 8'h00;
                            stp_q   <= 1'b1;
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    // The write has already been accepted, so DIR is ignored here.
                    data_q  <= 8'h00;
                    done_q  <= 1'b1;
                    state_q <= FINISH;
                end

                FINISH: begin
                    data_q  <= 8'h00;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    data_q  <= 8'h00;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign stp_o  = stp_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Directed bench for ulpi_reg_write. Each step drives the inputs for one
// cycle and pushes the output vector expected after the next clock edge onto
// a scoreboard queue. It then pops and compares that vector 1 ns after the edge.
module tb_ulpi_reg_write;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       stp;
        logic [7:0] data;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prw = 1'b0;
    logic [5:0] addr = 6'h00;
    logic [7:0] val = 8'h00;
    logic       dir = 1'b0;
    logic       nxt = 1'b0;
    logic       busy_o, done_o, err_o, stp_o;
    logic [7:0] data_o;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    string tag_q[$];

    ulpi_reg_write #(.MAX_RETRY(3)) dut (
        .clk_ulpi_i (clk),
        .rst_i      (rst),
        .prw_i      (prw),
        .addr_i     (addr),
        .reg_val_i  (val),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .dir_i      (dir),
        .nxt_i      (nxt),
        .data_o     (data_o),
        .stp_o      (stp_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(input logic b, input logic d, input logic e,
                                input logic s, input logic [7:0] x);
        obs_t o;
        o.busy = b; o.done = d; o.err = e; o.stp = s; o.data = x;
        return o;
    endfunction

    // Drive one cycle of inputs and check the outputs after the edge.
    task automatic cyc(input logic p, input logic d, input logic n,
                       input obs_t e, input string tag);
        obs_t  got, want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        prw = p; dir = d; nxt = n;
        @(posedge clk);
        #1;
        got  = {busy_o, done_o, err_o, stp_o, data_o};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed busy=%b done=%b err=%b stp=%b data=%h, expected busy=%b done=%b err=%b stp=%b data=%h",
                   t, got.busy, got.done, got.err, got.stp, got.data,
                   want.busy, want.done, want.err, want.stp, want.data);
        end
    endtask

    localparam obs_t IDLE_O = '{busy: 1'b0, done: 1'b0, err: 1'b0, stp: 1'b0, data: 8'h00};
    localparam obs_t WAIT_O = '{busy: 1'b1, done: 1'b0, err: 1'b0, stp: 1'b0, data: 8'h00};
    localparam obs_t STOP_O = '{busy: 1'b1, done: 1'b0, err: 1'b0, stp: 1'b1, data: 8'h00};
    localparam obs_t DONE_O = '{busy: 1'b1, done: 1'b1, err: 1'b0, stp: 1'b0, data: 8'h00};
    localparam obs_t ERR_O  = '{busy: 1'b1, done: 1'b0, err: 1'b1, stp: 1'b0, data: 8'h00};

    initial begin
        // Reset
        cyc(0, 0, 0, IDLE_O, "reset0");
        cyc(1, 0, 1, IDLE_O, "reset1_prw_ignored");
        rst = 1'b0;
        cyc(0, 0, 0, IDLE_O, "idle0");
        cyc(0, 0, 1, IDLE_O, "idle_nxt_ignored");

        // Basic write 0x16 <- 0xBA
        addr = 6'h16; val = 8'hBA;
        cyc(1, 0, 0, WAIT_O, "basic_c1");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h96), "basic_c2_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'hBA), "basic_c3_data");
        cyc(0, 0, 1, STOP_O, "basic_c4_stp");
        cyc(0, 0, 0, DONE_O, "basic_c5_done");
        cyc(0, 0, 0, IDLE_O, "basic_c6_idle");

        // NXT stalls of three cycles in each phase, 0x2A <- 0x55
        addr = 6'h2A; val = 8'h55;
        cyc(1, 0, 0, WAIT_O, "stall_wait");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'hAA), "stall_txcmd0");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, ob(1, 0, 0, 0, 8'hAA), "stall_txcmd_hold");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'h55), "stall_data0");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h55), "stall_data_hold");
        cyc(0, 0, 1, STOP_O, "stall_stp");
        cyc(0, 1, 1, DONE_O, "stall_done_dir_nxt_ignored");
        cyc(0, 0, 0, IDLE_O, "stall_idle");
        cyc(0, 0, 0, IDLE_O, "stall_settle");

        // Bus owned by PHY at request; extra requests ignored, 0x05 <- 0x11
        addr = 6'h05; val = 8'h11;
        cyc(1, 1, 0, WAIT_O, "busbusy_c1");
        addr = 6'h3F; val = 8'hFF;
        cyc(0, 1, 1, WAIT_O, "busbusy_c2");
        cyc(1, 1, 0, WAIT_O, "busbusy_c3_prw");
        cyc(0, 1, 0, WAIT_O, "busbusy_c4");
        cyc(1, 1, 0, WAIT_O, "busbusy_c5_prw");
        cyc(0, 0, 0, WAIT_O, "busbusy_turnaround");
        cyc(1, 0, 0, ob(1, 0, 0, 0, 8'h85), "busbusy_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'h11), "busbusy_data");
        cyc(0, 0, 1, STOP_O, "busbusy_stp");
        cyc(1, 0, 0, DONE_O, "busbusy_done_prw_ignored");
        cyc(0, 0, 0, IDLE_O, "busbusy_idle");

        // Abort in DATA phase for three cycles, then retry, 0x3C <- 0xE7
        addr = 6'h3C; val = 8'hE7;
        cyc(1, 0, 0, WAIT_O, "abort_wait");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'hBC), "abort_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'hE7), "abort_data");
        cyc(0, 1, 0, WAIT_O, "abort_dir1");
        cyc(0, 1, 1, WAIT_O, "abort_dir2");
        cyc(0, 1, 0, WAIT_O, "abort_dir3");
        cyc(0, 0, 0, WAIT_O, "abort_turnaround");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'hBC), "abort_retx_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'hE7), "abort_retx_data");
        cyc(0, 0, 1, STOP_O, "abort_stp");
        cyc(0, 0, 0, DONE_O, "abort_done");
        cyc(0, 0, 0, IDLE_O, "abort_idle");

        // Retry exhaustion: four aborts in TXCMD, 0x01 <- 0x33
        addr = 6'h01; val = 8'h33;
        cyc(1, 0, 0, WAIT_O, "exh_wait");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h81), "exh_txcmd0");
        for (int r = 0; r < 3; r++) begin
            cyc(0, 1, (r == 2), WAIT_O, "exh_abort_retry");
            cyc(0, 0, 0, WAIT_O, "exh_turnaround");
            cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h81), "exh_retx_txcmd");
        end
        cyc(0, 1, 1, ERR_O, "exh_err");
        cyc(1, 0, 0, IDLE_O, "exh_idle_prw_in_err_ignored");
        cyc(0, 0, 0, IDLE_O, "exh_idle2");

        // Reset during DATA phase, then a clean write 0x1F <- 0xAC
        addr = 6'h10; val = 8'h77;
        cyc(1, 0, 0, WAIT_O, "rst_wait");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h90), "rst_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'h77), "rst_data");
        rst = 1'b1;
        cyc(0, 0, 1, IDLE_O, "rst_applied");
        rst = 1'b0;
        cyc(0, 0, 0, IDLE_O, "rst_released");
        addr = 6'h1F; val = 8'hAC;
        cyc(1, 0, 0, WAIT_O, "post_wait");
        cyc(0, 0, 0, ob(1, 0, 0, 0, 8'h9F), "post_txcmd");
        cyc(0, 0, 1, ob(1, 0, 0, 0, 8'hAC), "post_data");
        cyc(0, 0, 1, STOP_O, "post_stp");
        cyc(0, 0, 0, DONE_O, "post_done");
        cyc(0, 0, 0, IDLE_O, "post_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_write.md
# ulpi_reg_write

Link-side ULPI register write engine, driven by the sniffer control logic to configure the USB3300 PHY (function control, OTG control, interface control). On a one-cycle request it waits for ownership of the ULPI bus and issues an immediate-address register-write TXCMD followed by the data byte. It then terminates the transfer with STP. It is the write counterpart of the register read engine and shares the same DATA_O/STP bus-drive conventions, so both can be muxed onto one ULPI port.

## Interface
- MAX_RETRY, 3: number of re-issues allowed after PHY aborts (DIR asserted mid-transfer) before giving up; width of retry counter = 2 bits at default, sized by $clog2(MAX_RETRY+1).
- clk_ULPI  input  1  60 MHz ULPI clock from PHY; single clock domain.
- rst  input  1  synchronous, active-high reset.
- PrW  input  1  write request pulse; sampled only while busy=0.
- ADDR  input  6  register address; latched on accepted PrW.
- REG_VAL  input  8  value to write; latched on accepted PrW.
- busy  output  1  high from cycle after accepted PrW until done/err cycle inclusive.
- done  output  1  one-cycle pulse: write acknowledged by PHY.
- err  output  1  one-cycle pulse: retries exhausted, write not performed.
- DIR  input  1  ULPI direction (1 = PHY owns bus).
- NXT  input  1  ULPI next.
- DATA_O  output  8  link-driven data; external tristate enabled when DIR=0.
- STP  output  1  ULPI stop.

## Operation
- All outputs registered. Reset values: busy=0, done=0, err=0, DATA_O=8'h00, STP=0, retry count=0, state IDLE.
- States: IDLE, WAIT_BUS, TXCMD, DATA, STOP, FINISH.
- IDLE: DATA_O=00, STP=0. PrW=1 -> latch ADDR/REG_VAL, clear retry count, go WAIT_BUS.
- WAIT_BUS: DATA_O=00. Requires DIR=0 in current and previous cycle (turnaround). Then go TXCMD; else stay.
- TXCMD: DATA_O = {2'b10, ADDR_latched}. Hold until NXT=1 sampled -> DATA.
- DATA: DATA_O = REG_VAL_latched. Hold until NXT=1 sampled -> STOP.
- STOP: STP=1, DATA_O=00 for exactly one cycle -> FINISH.
- FINISH: done=1, busy still 1 this cycle, STP=0 -> IDLE.
- Abort: DIR=1 sampled in TXCMD or DATA -> DATA_O=00 next cycle, no STP. If retry count < MAX_RETRY, increment it and go WAIT_BUS. Otherwise pulse err=1 with busy=1 that cycle, then IDLE.
- DIR=1 in STOP is ignored: the write is already accepted, so done is still reported.
- NXT while DIR=1, or in IDLE/WAIT_BUS/STOP/FINISH: ignored.
- PrW while busy=1: ignored, no queuing.
- Simultaneous DIR=1 and NXT=1 in TXCMD/DATA: abort takes priority.
- rst=1 in any state: next edge forces reset values; in-flight write dropped, no done/err.

## Timing
- Cycle 0: PrW=1 accepted (DIR=0 for ≥2 cycles).
- Cycle 1: busy=1, state WAIT_BUS.
- Cycle 2: DATA_O=TXCMD.
- NXT high at cycle k (k≥2) -> cycle k+1 DATA_O=REG_VAL.
- NXT high at cycle m -> cycle m+1 STP=1, DATA_O=00.
- Cycle m+2: done=1.
- Cycle m+3: busy=0, new PrW accepted.
- Minimum latency with NXT immediate: PrW at 0, TXCMD at 2, data at 3, STP at 4, done at 5.
- No timeout on NXT; upper logic owns watchdogs.

## Test plan
- Basic write: ADDR=0x16, REG_VAL=0xBA, NXT high on cycles 2 and 3 -> DATA_O 0x96 (cycle 2), 0xBA (3), STP=1/00 (4), done (5), busy low at 6.
- NXT stalls: NXT delayed 3 cycles each phase -> DATA_O holds 0x80|ADDR then REG_VAL for the full stall; STP occurs exactly one cycle after the second NXT.
- Bus busy at request: DIR=1 when PrW is issued, low 5 cycles later -> TXCMD appears 2 cycles after DIR falls; PrW pulses during busy are ignored.
- Abort and retry: DIR=1 during DATA phase for 3 cycles -> DATA_O=00, no STP; after the turnaround TXCMD is re-issued and completes with done, err=0.
- Retry exhaustion: DIR pulsed in TXCMD MAX_RETRY+1 times -> exactly one err pulse, no done, no STP, busy drops the next cycle.
- Reset mid-op: rst=1 during DATA phase -> next cycle all outputs at reset values. A subsequent write with ADDR=0x1F, REG_VAL=0xAC completes normally with DATA_O 0x9F then 0xAC.
